// File: rtl/render_pkg.sv
// Shared types and constants for the per-frame render sequencer.
package render_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR_WAIT,
    ST_ACCEPT,
    ST_RASTER,
    ST_DRAIN,
    ST_DONE
  } seq_state_t;

  localparam int MAX_TRIS_DEF = 256;
  localparam int TRI_CNT_W    = $clog2(MAX_TRIS_DEF + 1);
  localparam logic [7:0] OVERRUN_MAX = 8'hFF;

endpackage

// File: rtl/render_frame_sequencer.sv
// Per-frame controller: clears frame/depth buffers, then feeds triangles one at
// a time to the rasterizer and reports frame completion.
module render_frame_sequencer
  import render_pkg::*;
#(
  parameter int TRI_WIDTH    = 96,
  parameter int MAX_TRIS     = 256,
  parameter int CLEAR_SETTLE = 2
) (
  input  logic                             clk,
  input  logic                             rstn,
  input  logic                             i_frame,
  input  logic                             i_buf_ready,
  output logic                             o_clear,
  input  logic                             i_tri_valid,
  input  logic                             i_tri_last,
  input  logic [TRI_WIDTH-1:0]             i_tri_data,
  output logic                             o_tri_ready,
  output logic [TRI_WIDTH-1:0]             o_tri_data,
  output logic                             o_rast_start,
  input  logic                             i_rast_done,
  output logic                             o_frame_done,
  output logic                             o_busy,
  output logic [$clog2(MAX_TRIS+1)-1:0]    o_tri_count,
  output logic                             o_truncated,
  output logic [7:0]                       o_overrun_count
);

  localparam int CNT_W = $clog2(MAX_TRIS + 1);
  localparam int SET_W = $clog2(CLEAR_SETTLE + 1);

  seq_state_t           r_state;
  seq_state_t           w_state_nxt;
  logic                 r_clear;
  logic                 r_rast_start;
  logic                 r_last;
  logic                 r_truncated;
  logic [TRI_WIDTH-1:0] r_tri_data;
  logic [CNT_W-1:0]     r_tri_count;
  logic [SET_W-1:0]     r_settle;
  logic [7:0]           r_overrun;
  logic [CNT_W-1:0]     w_cnt_inc;
  logic                 w_tri_ready;
  logic                 w_frame_done;
  logic                 w_rast_ack;

  assign w_cnt_inc = r_tri_count + CNT_W'(1);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // A done pulse coincident with our own start pulse belongs to no triangle.
  always_comb begin
    w_state_nxt  = r_state;
    w_tri_ready  = 1'b0;
    w_frame_done = 1'b0;
    w_rast_ack   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_frame) w_state_nxt = ST_CLEAR_WAIT;
      end
      ST_CLEAR_WAIT: begin
        if (r_settle == '0 && i_buf_ready) w_state_nxt = ST_ACCEPT;
      end
      ST_ACCEPT: begin
        w_tri_ready = 1'b1;
        if (i_tri_valid) w_state_nxt = ST_RASTER;
      end
      ST_RASTER: begin
        if (i_rast_done && !r_rast_start) begin
          w_rast_ack = 1'b1;
          if (r_last)                             w_state_nxt = ST_DONE;
          else if (w_cnt_inc == CNT_W'(MAX_TRIS)) w_state_nxt = ST_DRAIN;
          else                                    w_state_nxt = ST_ACCEPT;
        end
      end
      ST_DRAIN: begin
        w_tri_ready = 1'b1;
        if (i_tri_valid && i_tri_last) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        w_frame_done = 1'b1;
        w_state_nxt  = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_clear      <= 1'b0;
      r_rast_start <= 1'b0;
      r_last       <= 1'b0;
      r_truncated  <= 1'b0;
      r_tri_data   <= '0;
      r_tri_count  <= '0;
      r_settle     <= '0;
      r_overrun    <= '0;
    end else begin
      r_clear      <= (r_state == ST_IDLE) && i_frame;
      r_rast_start <= (r_state == ST_ACCEPT) && i_tri_valid;

      if (r_state == ST_IDLE && i_frame) begin
        r_tri_count <= '0;
        r_truncated <= 1'b0;
        r_settle    <= SET_W'(CLEAR_SETTLE);
      end else if (r_state == ST_CLEAR_WAIT && r_settle != '0) begin
        r_settle <= r_settle - SET_W'(1);
      end

      if (r_state == ST_ACCEPT && i_tri_valid) begin
        r_tri_data <= i_tri_data;
        r_last     <= i_tri_last;
      end

      if (w_rast_ack) begin
        r_tri_count <= w_cnt_inc;
        if (!r_last && w_cnt_inc == CNT_W'(MAX_TRIS)) r_truncated <= 1'b1;
      end

      // Frames requested while busy (including the DONE cycle) are dropped.
      if (i_frame && r_state != ST_IDLE && r_overrun != OVERRUN_MAX)
        r_overrun <= r_overrun + 8'd1;
    end
  end

  assign o_clear         = r_clear;
  assign o_tri_ready     = w_tri_ready;
  assign o_tri_data      = r_tri_data;
  assign o_rast_start    = r_rast_start;
  assign o_frame_done    = w_frame_done;
  assign o_busy          = (r_state != ST_IDLE);
  assign o_tri_count     = r_tri_count;
  assign o_truncated     = r_truncated;
  assign o_overrun_count = r_overrun;

endmodule
